xsim_sink_arbiter: RTL and testbench
====================================

XSIM_SINK_ARBITER -- requirements
Module: xsim_sink_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter NUM_PORTALS, default 4, SHALL set the number of requesting message-sink channels (2..16).
REQ-003 Parameter IDX_W, default 2, SHALL set the width of the grant index; IDX_W = clog2(NUM_PORTALS).
REQ-004 Port CLK  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-005 Port RST  input  1  SHALL be the asynchronous active-high reset.
REQ-006 Port in_rdy  input  NUM_PORTALS  SHALL carry the per-channel beat-valid flags.
REQ-007 Port in_beat  input  32*NUM_PORTALS  SHALL carry the per-channel 32-bit beats; channel i occupies bits [32i+31:32i].
REQ-008 Port in_en  output  NUM_PORTALS  SHALL carry the per-channel beat-consume strobes.
REQ-009 Port RDY_beat  output  1  SHALL be the merged-stream valid flag.
REQ-010 Port EN_beat  input  1  SHALL be the merged-stream consume strobe from downstream.
REQ-011 Port beat  output  32  SHALL be the merged-stream beat.
REQ-012 Port grant_idx  output  IDX_W  SHALL be the channel index currently granted.
REQ-013 Port stall_err  output  1  SHALL be the sticky stall-timeout flag.

Function
REQ-014 The state machine SHALL have two states: IDLE and BURST.
REQ-015 In IDLE, RDY_beat, in_en and beat SHALL all be 0.
REQ-016 In IDLE, when any in_rdy bit is set, the block SHALL register as grant the first set channel searching upward from last_grant+1 (mod NUM_PORTALS); it SHALL then enter BURST with first=1.
REQ-017 In IDLE with no in_rdy bit set, the state SHALL remain IDLE.
REQ-018 In BURST, RDY_beat SHALL equal in_rdy[grant], and beat SHALL equal in_beat[grant] (combinational, zero-latency forward).
REQ-019 In BURST, in_en[grant] SHALL equal EN_beat AND in_rdy[grant]; all other in_en bits SHALL be 0.
REQ-020 An EN_beat pulse while RDY_beat=0 SHALL be ignored and SHALL NOT change any state.
REQ-021 The first consumed beat of a burst is the message header.
REQ-022 The header's bits [15:0] give the total message length L in words, including the header.
REQ-023 L=0 SHALL be treated as L=1.
REQ-024 On header consume: if L<=1, the block SHALL return to IDLE; otherwise it SHALL load beats_left = L-1 (16-bit) and clear first.
REQ-025 On each later consume, beats_left SHALL decrement by 1; the consume that makes beats_left reach 0 SHALL return the block to IDLE.
REQ-026 On every return to IDLE, last_grant SHALL be set to grant.
REQ-027 A granted message SHALL never be interleaved with beats from another channel.
REQ-028 Requester bubbles (in_rdy[grant]=0) SHALL hold the grant.
REQ-029 There SHALL be exactly one IDLE arbitration cycle between consecutive messages, so the sustained rate is L beats per L+1 cycles.
REQ-030 grant_idx SHALL equal grant in BURST and last_grant in IDLE.

Reset
REQ-031 While RST=1, the block SHALL force asynchronously: state=IDLE, grant=0, last_grant=NUM_PORTALS-1, beats_left=0, first=1, stall_err=0.
REQ-032 Consequently, during reset RDY_beat=0, in_en=0, beat=0, and grant_idx=NUM_PORTALS-1.
REQ-033 Reset asserted mid-burst SHALL abort the message, with no further in_en pulses; after release, channel 0 SHALL have first priority.

Configuration
REQ-034 Macro XSIM_SINK_ARB_STALL_TIMEOUT_EN SHALL compile the stall watchdog in or out.
REQ-035 When XSIM_SINK_ARB_STALL_TIMEOUT_EN is defined, an 8-bit counter SHALL increment each BURST cycle with in_rdy[grant]=0 and clear on any consume or in IDLE.
REQ-036 When XSIM_SINK_ARB_STALL_TIMEOUT_EN is defined and the counter reaches 255, the block SHALL set stall_err=1 (sticky until reset), abandon the message and enter IDLE.
REQ-037 When XSIM_SINK_ARB_STALL_TIMEOUT_EN is undefined, stall_err SHALL be tied 0 and a grant SHALL be held indefinitely.

Verification
REQ-038 Reset release, then channel 2 offers header 0x0001_0003 followed by 2 data beats, with EN_beat held 1 -> grant_idx=2; 3 beats emitted on consecutive cycles; in_en[2] pulses 3 times; IDLE in cycle 5.
REQ-039 All 4 channels continuously ready with length-1 messages -> grant order 0,1,2,3,0,...; one beat every 2 cycles.
REQ-040 Channel 1 L=4 in progress while channel 0 becomes ready -> channel 0 gets no in_en pulse until channel 1's fourth beat is consumed; then channel 0 is granted.
REQ-041 Header length field 0x0000 -> treated as a 1-beat message; return to IDLE after the header.
REQ-042 RST asserted asynchronously (mid-cycle) after 2 of 5 beats -> RDY_beat and in_en drop immediately; after release, a new header from channel 3 is accepted as a header.
REQ-043 With the macro defined, the granted channel drops in_rdy for 255 cycles mid-message -> stall_err=1 and state IDLE; without the macro, the grant is held and stall_err=0.

Source files
------------

// File: rtl/xsim_sink_arbiter.sv
// Round-robin merge of NUM_PORTALS message-sink channels into one beat stream.
// Define XSIM_SINK_ARB_STALL_TIMEOUT_EN to build in the stall watchdog.
module xsim_sink_arbiter #(
  parameter int NUM_PORTALS = 4,
  parameter int IDX_W       = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_PORTALS-1:0]    in_rdy,
  input  logic [32*NUM_PORTALS-1:0] in_beat,
  output logic [NUM_PORTALS-1:0]    in_en,
  output logic                      RDY_beat,
  input  logic                      EN_beat,
  output logic [31:0]               beat,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      stall_err
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] lastGrant_q, lastGrant_d;
  logic [15:0]      beatsLeft_q, beatsLeft_d;
  logic             first_q, first_d;
  logic             stallErr_q, stallErr_d;

  logic             selRdy;
  logic [31:0]      selBeat;
  logic             consume;
  logic [15:0]      hdrLen;
  logic             anyReq;
  logic             found;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] arbWinner;
  logic             stallHit;

  assign selRdy  = in_rdy[grant_q];
  assign selBeat = in_beat[{grant_q, 5'b00000} +: 32];
  assign consume = (state_q == BURST) && EN_beat && selRdy;
  assign hdrLen  = selBeat[15:0];
  assign anyReq  = |in_rdy;

  // Rotating priority: search upward starting just after the last served channel.
  always_comb begin
    arbWinner = lastGrant_q;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_PORTALS; k++) begin
      cand = IDX_W'((int'(lastGrant_q) + k) % NUM_PORTALS);
      if (!found && in_rdy[cand]) begin
        arbWinner = cand;
        found     = 1'b1;
      end
    end
  end

`ifdef XSIM_SINK_ARB_STALL_TIMEOUT_EN
  logic [7:0] stallCnt_q, stallCnt_d;

  always_comb begin
    stallCnt_d = '0;
    if (state_q == BURST && !selRdy) stallCnt_d = stallCnt_q + 8'd1;
  end

  // Counter lands on 255 in the same edge that abandons the message.
  assign stallHit = (state_q == BURST) && !selRdy && (stallCnt_q == 8'd254);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) stallCnt_q <= '0;
    else     stallCnt_q <= stallCnt_d;
  end
`else
  assign stallHit = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      lastGrant_q <= IDX_W'(NUM_PORTALS - 1);
      beatsLeft_q <= '0;
      first_q     <= 1'b1;
      stallErr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      beatsLeft_q <= beatsLeft_d;
      first_q     <= first_d;
      stallErr_q  <= stallErr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    beatsLeft_d = beatsLeft_q;
    first_d     = first_q;
    stallErr_d  = stallErr_q;
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          grant_d = arbWinner;
          first_d = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        if (stallHit) begin
          stallErr_d  = 1'b1;
          lastGrant_d = grant_q;
          beatsLeft_d = '0;
          first_d     = 1'b1;
          state_d     = IDLE;
        end else if (consume) begin
          if (first_q) begin
            // A zero length field still describes a header-only message.
            if (hdrLen <= 16'd1) begin
              lastGrant_d = grant_q;
              state_d     = IDLE;
            end else begin
              beatsLeft_d = hdrLen - 16'd1;
              first_d     = 1'b0;
            end
          end else begin
            beatsLeft_d = beatsLeft_q - 16'd1;
            if (beatsLeft_q == 16'd1) begin
              lastGrant_d = grant_q;
              first_d     = 1'b1;
              state_d     = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_en     = '0;
    RDY_beat  = 1'b0;
    beat      = '0;
    grant_idx = lastGrant_q;
    if (state_q == BURST) begin
      RDY_beat       = selRdy;
      beat           = selBeat;
      in_en[grant_q] = EN_beat && selRdy;
      grant_idx      = grant_q;
    end
  end

  assign stall_err = stallErr_q;

endmodule

// File: tb/tb_xsim_sink_arbiter.sv
// Bench for xsim_sink_arbiter: vector table, directed corner sequences and a
// randomized run against a message-level reference model.
module tb_xsim_sink_arbiter;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [3:0]   in_rdy = '0;
  logic [127:0] in_beat = '0;
  logic [3:0]   in_en;
  logic         RDY_beat;
  logic         EN_beat = 1'b0;
  logic [31:0]  beat;
  logic [1:0]   grant_idx;
  logic         stall_err;

  int errCount   = 0;
  int checkCount = 0;

  xsim_sink_arbiter #(.NUM_PORTALS(4), .IDX_W(2)) dut (
    .CLK(CLK), .RST(RST), .in_rdy(in_rdy), .in_beat(in_beat), .in_en(in_en),
    .RDY_beat(RDY_beat), .EN_beat(EN_beat), .beat(beat),
    .grant_idx(grant_idx), .stall_err(stall_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  rdy;
    int          src;
    logic [31:0] b;
    logic        en;
    logic        expRdy;
    logic [3:0]  expEn;
    logic [31:0] expBeat;
    logic [1:0]  expGidx;
  } vec_t;

  vec_t tbl[12];

  task automatic applyStimulus(input logic [3:0] rdy, input logic [127:0] beats, input logic en);
    in_rdy  = rdy;
    in_beat = beats;
    EN_beat = en;
  endtask

  task automatic checkOutput(input string name, input logic eRdy, input logic [3:0] eEn,
                             input logic [31:0] eBeat, input logic [1:0] eG, input logic eErr);
    checkCount++;
    if (RDY_beat !== eRdy || in_en !== eEn || beat !== eBeat || grant_idx !== eG || stall_err !== eErr) begin
      errCount++;
      $display("[TB] FAIL %s: got RDY_beat=%0b in_en=%b beat=%h grant_idx=%0d stall_err=%0b, want %0b %b %h %0d %0b",
               name, RDY_beat, in_en, beat, grant_idx, stall_err, eRdy, eEn, eBeat, eG, eErr);
    end
  endtask

  // Granted-channel word goes on src, every other channel sees its complement.
  function automatic logic [127:0] mkBeats(input int src, input logic [31:0] b);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = (i == src) ? b : ~b;
    return r;
  endfunction

  task automatic resetDut();
    RST = 1'b1;
    applyStimulus(4'hF, {4{32'h0000_0002}}, 1'b1);
    repeat (2) @(negedge CLK);
    #1 checkOutput("reset", 1'b0, 4'h0, 32'h0, 2'd3, 1'b0);
    @(negedge CLK);
    applyStimulus(4'h0, '0, 1'b0);
    RST = 1'b0;
  endtask

  // Reference model: message-level bookkeeping per channel.
  logic [31:0] chBuf[4][8];
  int          chLen[4];
  int          chPos[4];
  bit          mBusy;
  int          mCh, mLast, mLeft;

  task automatic runRandom(input int cycles);
    logic [3:0]   rdy;
    logic [127:0] beats;
    logic         en;
    logic         eRdy;
    logic [3:0]   eEn;
    logic [31:0]  eBeat;
    logic [1:0]   eG;
    int           len, n, c, hdrL;
    mBusy = 0; mCh = 0; mLast = 3; mLeft = -1;
    for (int i = 0; i < 4; i++) begin chLen[i] = 0; chPos[i] = 0; end
    for (int cyc = 0; cyc < cycles; cyc++) begin
      @(negedge CLK);
      for (int i = 0; i < 4; i++) begin
        if (chPos[i] >= chLen[i] && $urandom_range(0, 2) == 0) begin
          len = $urandom_range(0, 5);
          n = (len == 0) ? 1 : len;
          chBuf[i][0] = {16'($urandom), 16'(len)};
          for (int j = 1; j < n; j++) chBuf[i][j] = $urandom;
          chLen[i] = n;
          chPos[i] = 0;
        end
        rdy[i] = (chPos[i] < chLen[i]) && ($urandom_range(0, 4) != 0);
        beats[i*32 +: 32] = (chPos[i] < chLen[i]) ? chBuf[i][chPos[i]] : 32'($urandom);
      end
      en = ($urandom_range(0, 3) != 0);
      applyStimulus(rdy, beats, en);
      #1;
      eRdy = 1'b0; eEn = '0; eBeat = '0; eG = 2'(mLast);
      if (mBusy) begin
        eRdy = rdy[mCh];
        eBeat = beats[mCh*32 +: 32];
        eEn[mCh] = en && rdy[mCh];
        eG = 2'(mCh);
      end
      checkOutput("random", eRdy, eEn, eBeat, eG, 1'b0);
      if (mBusy) begin
        if (en && rdy[mCh]) begin
          if (mLeft < 0) begin
            hdrL = int'(beats[mCh*32 +: 16]);
            mLeft = ((hdrL == 0) ? 1 : hdrL) - 1;
          end else begin
            mLeft--;
          end
          chPos[mCh]++;
          if (mLeft == 0) begin
            mBusy = 0;
            mLast = mCh;
          end
        end
      end else if (|rdy) begin
        for (int k = 4; k >= 1; k--) begin
          c = (mLast + k) % 4;
          if (rdy[c]) mCh = c;
        end
        mBusy = 1;
        mLeft = -1;
      end
    end
  endtask

  initial begin
    tbl[0]  = '{4'b0100, 2, 32'h0001_0003, 1'b1, 1'b0, 4'b0000, 32'h0000_0000, 2'd3};
    tbl[1]  = '{4'b0100, 2, 32'h0001_0003, 1'b1, 1'b1, 4'b0100, 32'h0001_0003, 2'd2};
    tbl[2]  = '{4'b0100, 2, 32'hDEAD_0001, 1'b1, 1'b1, 4'b0100, 32'hDEAD_0001, 2'd2};
    tbl[3]  = '{4'b0100, 2, 32'hDEAD_0002, 1'b1, 1'b1, 4'b0100, 32'hDEAD_0002, 2'd2};
    tbl[4]  = '{4'b0000, 2, 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 32'h0000_0000, 2'd2};
    tbl[5]  = '{4'b0010, 1, 32'hABCD_0000, 1'b1, 1'b0, 4'b0000, 32'h0000_0000, 2'd2};
    tbl[6]  = '{4'b0010, 1, 32'hABCD_0000, 1'b1, 1'b1, 4'b0010, 32'hABCD_0000, 2'd1};
    tbl[7]  = '{4'b0010, 1, 32'h0000_0001, 1'b1, 1'b0, 4'b0000, 32'h0000_0000, 2'd1};
    tbl[8]  = '{4'b0000, 1, 32'h0000_0001, 1'b1, 1'b0, 4'b0000, 32'h0000_0001, 2'd1};
    tbl[9]  = '{4'b0010, 1, 32'h0000_0001, 1'b0, 1'b1, 4'b0000, 32'h0000_0001, 2'd1};
    tbl[10] = '{4'b0010, 1, 32'h0000_0001, 1'b1, 1'b1, 4'b0010, 32'h0000_0001, 2'd1};
    tbl[11] = '{4'b0000, 1, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 32'h0000_0000, 2'd1};

    resetDut();
    for (int r = 0; r < 12; r++) begin
      @(negedge CLK);
      applyStimulus(tbl[r].rdy, mkBeats(tbl[r].src, tbl[r].b), tbl[r].en);
      #1 checkOutput($sformatf("table_row%0d", r), tbl[r].expRdy, tbl[r].expEn,
                     tbl[r].expBeat, tbl[r].expGidx, 1'b0);
    end

    // All channels always ready with single-beat messages.
    resetDut();
    @(negedge CLK);
    applyStimulus(4'hF, {32'h0300_0001, 32'h0200_0001, 32'h0100_0001, 32'h0000_0001}, 1'b1);
    for (int m = 0; m < 8; m++) begin
      #1 checkOutput("rr_idle", 1'b0, 4'h0, 32'h0, 2'((m + 3) % 4), 1'b0);
      @(negedge CLK);
      #1 checkOutput("rr_burst", 1'b1, 4'(1 << (m % 4)), {8'(m % 4), 24'h00_0001}, 2'(m % 4), 1'b0);
      @(negedge CLK);
    end

    // Channel 1 four-beat message must not be interleaved with channel 0.
    resetDut();
    @(negedge CLK);
    applyStimulus(4'b0010, {64'h0, 32'h0000_0004, 32'h0000_0001}, 1'b1);
    #1 checkOutput("nointl_idle", 1'b0, 4'h0, 32'h0, 2'd3, 1'b0);
    for (int j = 0; j < 4; j++) begin
      @(negedge CLK);
      applyStimulus(4'b0011, {64'h0, (j == 0) ? 32'h0000_0004 : 32'h4000_0000 + 32'(j), 32'h0000_0001}, 1'b1);
      #1 checkOutput("nointl_ch1", 1'b1, 4'b0010, (j == 0) ? 32'h0000_0004 : 32'h4000_0000 + 32'(j), 2'd1, 1'b0);
    end
    @(negedge CLK);
    applyStimulus(4'b0001, {64'h0, 32'h0, 32'h0000_0001}, 1'b1);
    #1 checkOutput("nointl_gap", 1'b0, 4'h0, 32'h0, 2'd1, 1'b0);
    @(negedge CLK);
    #1 checkOutput("nointl_ch0", 1'b1, 4'b0001, 32'h0000_0001, 2'd0, 1'b0);

    // Asynchronous reset mid-message, then a fresh header on channel 3.
    resetDut();
    @(negedge CLK);
    applyStimulus(4'b1000, mkBeats(3, 32'h5555_0005), 1'b1);
    #1 checkOutput("arst_idle", 1'b0, 4'h0, 32'h0, 2'd3, 1'b0);
    @(negedge CLK);
    #1 checkOutput("arst_hdr", 1'b1, 4'b1000, 32'h5555_0005, 2'd3, 1'b0);
    @(negedge CLK);
    applyStimulus(4'b1000, mkBeats(3, 32'h1111_1111), 1'b1);
    #1 checkOutput("arst_d1", 1'b1, 4'b1000, 32'h1111_1111, 2'd3, 1'b0);
    @(negedge CLK);
    applyStimulus(4'b1000, mkBeats(3, 32'h2222_2222), 1'b1);
    #1 checkOutput("arst_d2", 1'b1, 4'b1000, 32'h2222_2222, 2'd3, 1'b0);
    #1 RST = 1'b1;
    #1 checkOutput("arst_drop", 1'b0, 4'h0, 32'h0, 2'd3, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    applyStimulus(4'b1000, mkBeats(3, 32'hCAFE_0002), 1'b1);
    #1 checkOutput("arst_rel_idle", 1'b0, 4'h0, 32'h0, 2'd3, 1'b0);
    @(negedge CLK);
    #1 checkOutput("arst_newhdr", 1'b1, 4'b1000, 32'hCAFE_0002, 2'd3, 1'b0);
    @(negedge CLK);
    applyStimulus(4'b1000, mkBeats(3, 32'h3333_3333), 1'b1);
    #1 checkOutput("arst_newdata", 1'b1, 4'b1000, 32'h3333_3333, 2'd3, 1'b0);
    @(negedge CLK);
    applyStimulus(4'b0000, '0, 1'b0);
    #1 checkOutput("arst_done", 1'b0, 4'h0, 32'h0, 2'd3, 1'b0);

    // Granted requester goes silent mid-message.
    resetDut();
    @(negedge CLK);
    applyStimulus(4'b0100, mkBeats(2, 32'h0000_0003), 1'b1);
    #1 checkOutput("stall_idle", 1'b0, 4'h0, 32'h0, 2'd3, 1'b0);
    @(negedge CLK);
    #1 checkOutput("stall_hdr", 1'b1, 4'b0100, 32'h0000_0003, 2'd2, 1'b0);
    for (int k = 0; k < 255; k++) begin
      @(negedge CLK);
      applyStimulus(4'b0000, mkBeats(2, 32'h7777_0001), 1'b1);
      #1;
      if (k == 254) checkOutput("stall_pre", 1'b0, 4'h0, 32'h7777_0001, 2'd2, 1'b0);
    end
    @(negedge CLK);
    applyStimulus(4'b0100, mkBeats(2, 32'h7777_0001), 1'b1);
`ifdef XSIM_SINK_ARB_STALL_TIMEOUT_EN
    #1 checkOutput("stall_timeout", 1'b0, 4'h0, 32'h0, 2'd2, 1'b1);
`else
    #1 checkOutput("stall_hold", 1'b1, 4'b0100, 32'h7777_0001, 2'd2, 1'b0);
`endif

    resetDut();
    runRandom(1500);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
